// File: rtl/andla_exram_base_rf_if.sv
// Host configuration bus for the external-RAM base register stage.
interface andla_exram_base_rf_if;
  logic        cfg_req;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_gnt;
  logic        cfg_rvalid;
  logic [31:0] cfg_rdata;
  logic        cfg_err;

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_gnt, cfg_rvalid, cfg_rdata, cfg_err
  );

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
    output cfg_gnt, cfg_rvalid, cfg_rdata, cfg_err
  );
endinterface

// File: rtl/andla_exram_base_rf.sv
// Shadowed, busy-deferred commit stage for the eight external-RAM base addresses.
// Optional ANDLA_EXRAM_BASE_ALIGN_EN forces 4 KiB alignment of committed addresses.
module andla_exram_base_entry #(
  parameter int BW = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          eng_busy,
  input  logic          wr_lsb,
  input  logic          wr_msb,
  input  logic [31:0]   wdata,
  output logic [BW-1:0] live,
  output logic          pending,
  output logic          commit_pulse
);
  localparam int MW = BW - 32;

  typedef enum logic [1:0] {IDLE, LSB_HELD, PEND} state_t;

  state_t        state;
  logic [31:0]   shadow_lsb;
  logic [MW-1:0] shadow_msb;
  logic [31:0]   lsb_in;
  logic [BW-1:0] commit_val;
  logic          commit;

  // A fresh MSB write supersedes whatever was already staged as pending.
  always_comb begin
    lsb_in     = wdata;
    commit_val = {shadow_msb, shadow_lsb};
    if (wr_msb) commit_val = {wdata[MW-1:0], shadow_lsb};
`ifdef ANDLA_EXRAM_BASE_ALIGN_EN
    lsb_in[11:0]     = '0;
    commit_val[11:0] = '0;
`endif
    commit = ~eng_busy & (wr_msb | (state == PEND));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= 1'b0;
      commit_pulse <= 1'b0;
      live         <= '0;
      shadow_lsb   <= '0;
      shadow_msb   <= '0;
    end else begin
      commit_pulse <= commit;
      if (commit) begin
        live       <= commit_val;
        shadow_lsb <= commit_val[31:0];
        shadow_msb <= commit_val[BW-1:32];
      end
      // An LSB write granted on the release edge lands after the old pending commit.
      if (wr_lsb) shadow_lsb <= lsb_in;
      if (wr_msb && eng_busy) shadow_msb <= wdata[MW-1:0];
      if (wr_msb) begin
        state   <= eng_busy ? PEND : IDLE;
        pending <= eng_busy;
      end else if (wr_lsb) begin
        state   <= LSB_HELD;
        pending <= 1'b0;
      end else if (commit) begin
        state   <= IDLE;
        pending <= 1'b0;
      end
    end
  end
endmodule

module andla_exram_base_rf #(
  parameter int BASE_BITWIDTH = 48,
  parameter int NUM_BASE      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  andla_exram_base_rf_if.slave     cfg,
  input  logic                     eng_busy,
  output logic [NUM_BASE-1:0]      pending,
  output logic [NUM_BASE-1:0]      commit_pulse,
  output logic [BASE_BITWIDTH-1:0] rf_csr_exram_based_addr_0,
  output logic [BASE_BITWIDTH-1:0] rf_csr_exram_based_addr_1,
  output logic [BASE_BITWIDTH-1:0] rf_csr_exram_based_addr_2,
  output logic [BASE_BITWIDTH-1:0] rf_csr_exram_based_addr_3,
  output logic [BASE_BITWIDTH-1:0] rf_csr_exram_based_addr_4,
  output logic [BASE_BITWIDTH-1:0] rf_csr_exram_based_addr_5,
  output logic [BASE_BITWIDTH-1:0] rf_csr_exram_based_addr_6,
  output logic [BASE_BITWIDTH-1:0] rf_csr_exram_based_addr_7
);
  localparam int MW = BASE_BITWIDTH - 32;

  if (BASE_BITWIDTH < 33 || BASE_BITWIDTH > 64 || NUM_BASE != 8) begin : g_bad_cfg
    $error("andla_exram_base_rf: unsupported parameterization");
  end

  logic [NUM_BASE-1:0][BASE_BITWIDTH-1:0] live;
  logic [NUM_BASE-1:0] wr_lsb, wr_msb;
  logic [2:0]  entry;
  logic        half, oor, stall, wr_ok, rd_ok, align_err;
  logic [31:0] rd_word;

  assign entry = cfg.cfg_addr[3:1];
  assign half  = cfg.cfg_addr[0];
  assign oor   = cfg.cfg_addr[4];

  // Writes to an entry still waiting on the engine are held off until it frees up.
  assign stall       = cfg.cfg_we & ~oor & pending[entry] & eng_busy;
  assign cfg.cfg_gnt = cfg.cfg_req & ~stall;
  assign wr_ok       = cfg.cfg_gnt & cfg.cfg_we & ~oor;
  assign rd_ok       = cfg.cfg_gnt & ~cfg.cfg_we;

`ifdef ANDLA_EXRAM_BASE_ALIGN_EN
  assign align_err = wr_ok & ~half & (cfg.cfg_wdata[11:0] != 12'd0);
`else
  assign align_err = 1'b0;
`endif

  for (genvar i = 0; i < NUM_BASE; i++) begin : g_entry
    assign wr_lsb[i] = wr_ok & ~half & (entry == 3'(i));
    assign wr_msb[i] = wr_ok &  half & (entry == 3'(i));

    andla_exram_base_entry #(.BW(BASE_BITWIDTH)) u_entry (
      .clk          (clk),
      .rst          (rst),
      .eng_busy     (eng_busy),
      .wr_lsb       (wr_lsb[i]),
      .wr_msb       (wr_msb[i]),
      .wdata        (cfg.cfg_wdata),
      .live         (live[i]),
      .pending      (pending[i]),
      .commit_pulse (commit_pulse[i])
    );
  end

  // Reads only ever see committed values, never the shadows.
  always_comb begin
    rd_word = '0;
    if (!oor) begin
      if (half) rd_word[MW-1:0] = live[entry][BASE_BITWIDTH-1:32];
      else      rd_word         = live[entry][31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg.cfg_rvalid <= 1'b0;
      cfg.cfg_rdata  <= '0;
      cfg.cfg_err    <= 1'b0;
    end else begin
      cfg.cfg_rvalid <= rd_ok;
      if (rd_ok) cfg.cfg_rdata <= rd_word;
      cfg.cfg_err <= (cfg.cfg_gnt & oor) | align_err;
    end
  end

  assign rf_csr_exram_based_addr_0 = live[0];
  assign rf_csr_exram_based_addr_1 = live[1];
  assign rf_csr_exram_based_addr_2 = live[2];
  assign rf_csr_exram_based_addr_3 = live[3];
  assign rf_csr_exram_based_addr_4 = live[4];
  assign rf_csr_exram_based_addr_5 = live[5];
  assign rf_csr_exram_based_addr_6 = live[6];
  assign rf_csr_exram_based_addr_7 = live[7];
endmodule

// File: tb/tb_andla_exram_base_rf.sv
// Scoreboard bench: driver feeds a staged-address reference model, monitor checks DUT outputs.
module tb_andla_exram_base_rf;
  localparam int BW = 48;
  localparam int MW = BW - 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eng_busy = 1'b0;
  logic [7:0] pending, commit_pulse;
  logic [7:0][BW-1:0] dut_live;

  andla_exram_base_rf_if cfg();

  andla_exram_base_rf #(.BASE_BITWIDTH(BW), .NUM_BASE(8)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .cfg                       (cfg),
    .eng_busy                  (eng_busy),
    .pending                   (pending),
    .commit_pulse              (commit_pulse),
    .rf_csr_exram_based_addr_0 (dut_live[0]),
    .rf_csr_exram_based_addr_1 (dut_live[1]),
    .rf_csr_exram_based_addr_2 (dut_live[2]),
    .rf_csr_exram_based_addr_3 (dut_live[3]),
    .rf_csr_exram_based_addr_4 (dut_live[4]),
    .rf_csr_exram_based_addr_5 (dut_live[5]),
    .rf_csr_exram_based_addr_6 (dut_live[6]),
    .rf_csr_exram_based_addr_7 (dut_live[7])
  );

  always #5 clk = ~clk;

`ifdef ANDLA_EXRAM_BASE_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          rv;
    logic [31:0] data;
    bit          err;
  } resp_t;

  // Reference model: committed value, staged value and a pending flag per entry.
  logic [BW-1:0] m_live [8];
  logic [BW-1:0] m_stg  [8];
  logic [7:0]    m_pend = '0;
  logic [7:0]    m_cp   = '0;
  resp_t         q[$];
  int vectors = 0, miscompares = 0, cyc = 0;

  initial for (int i = 0; i < 8; i++) begin m_live[i] = '0; m_stg[i] = '0; end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] amask(input logic [BW-1:0] v);
    logic [BW-1:0] r = v;
    if (ALIGN) r[11:0] = '0;
    return r;
  endfunction

  task automatic commit_entry(input int i);
    m_live[i] = amask(m_stg[i]);
    m_stg[i]  = m_live[i];
    m_pend[i] = 1'b0;
    m_cp[i]   = 1'b1;
  endtask

  task automatic step(input bit r_rst, input bit r, input bit w, input logic [4:0] a,
                      input logic [31:0] d, input bit b);
    bit oor, h, stall, gnt, aerr;
    int e;
    logic [BW-1:0] v;
    resp_t t;
    rst = r_rst; eng_busy = b;
    cfg.cfg_req = r; cfg.cfg_we = w; cfg.cfg_addr = a; cfg.cfg_wdata = d;
    #1;
    oor   = a[4];
    h     = a[0];
    e     = int'(a[3:1]);
    stall = r && w && !oor && m_pend[e] && b;
    gnt   = r && !stall;
    chk("gnt", {63'd0, cfg.cfg_gnt}, {63'd0, gnt});
    m_cp = '0;
    if (r_rst) begin
      for (int i = 0; i < 8; i++) begin m_live[i] = '0; m_stg[i] = '0; end
      m_pend = '0;
    end else begin
      aerr = ALIGN && w && !oor && !h && (d[11:0] != 12'd0);
      if (gnt && (!w || oor || aerr)) begin
        t.due  = cyc + 1;
        t.rv   = !w;
        t.err  = oor || aerr;
        t.data = (oor || w) ? 32'd0 : (h ? 32'(m_live[e][BW-1:32]) : m_live[e][31:0]);
        q.push_back(t);
      end
      if (!b) for (int i = 0; i < 8; i++) if (m_pend[i]) commit_entry(i);
      if (gnt && w && !oor) begin
        v = m_stg[e];
        if (!h) begin
          v[31:0]  = d;
          m_stg[e] = amask(v);
        end else begin
          v[BW-1:32] = d[MW-1:0];
          m_stg[e]   = v;
          if (b) m_pend[e] = 1'b1;
          else   commit_entry(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    resp_t t;
    for (int i = 0; i < 8; i++) chk($sformatf("live%0d", i), 64'(dut_live[i]), 64'(m_live[i]));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("commit_pulse", 64'(commit_pulse), 64'(m_cp));
    if (q.size() > 0 && q[0].due == cyc) begin
      t = q.pop_front();
      chk("rvalid", {63'd0, cfg.cfg_rvalid}, {63'd0, t.rv});
      chk("err", {63'd0, cfg.cfg_err}, {63'd0, t.err});
      if (t.rv) chk("rdata", 64'(cfg.cfg_rdata), 64'(t.data));
    end else begin
      chk("idle rvalid/err", {62'd0, cfg.cfg_rvalid, cfg.cfg_err}, 64'd0);
    end
  end

  initial begin
    logic [4:0] a;
    logic [31:0] d;
    bit b = 1'b0;
    step(1, 0, 0, 5'd0, 32'd0, 0);
    step(1, 0, 0, 5'd0, 32'd0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 5'(i), 32'd0, 0);
    // Entry 2 assembled from LSB then MSB, not busy.
    step(0, 1, 1, 5'd4, 32'h89AB_C000, 0);
    step(0, 1, 0, 5'd5, 32'd0, 0);
    step(0, 1, 1, 5'd5, 32'h0000_0012, 0);
    step(0, 1, 0, 5'd4, 32'd0, 0);
    step(0, 1, 0, 5'd5, 32'd0, 0);
    // Entries 0 and 5 deferred under busy; further write to 5 stalls.
    step(0, 1, 1, 5'd0, 32'hDEAD_B000, 1);
    step(0, 1, 1, 5'd1, 32'h0000_0A0A, 1);
    step(0, 1, 1, 5'd10, 32'h5555_6000, 1);
    step(0, 1, 1, 5'd11, 32'h0000_7777, 1);
    step(0, 1, 1, 5'd11, 32'h0000_1111, 1);
    step(0, 0, 0, 5'd0, 32'd0, 0);
    step(0, 1, 0, 5'd11, 32'd0, 0);
    // MSB-only write keeps the live LSB.
    step(0, 1, 1, 5'd14, 32'h1234_5000, 0);
    step(0, 1, 1, 5'd15, 32'h0000_0000, 0);
    step(0, 1, 1, 5'd15, 32'h0000_0001, 0);
    step(0, 1, 0, 5'd15, 32'd0, 0);
    // Out-of-range write and read.
    step(0, 1, 1, 5'h10, 32'hFFFF_FFFF, 0);
    step(0, 1, 0, 5'h11, 32'd0, 0);
    // Reset while entry 3 is pending drops it.
    step(0, 1, 1, 5'd6, 32'hABCD_E000, 1);
    step(0, 1, 1, 5'd7, 32'h0000_0042, 1);
    step(1, 0, 0, 5'd0, 32'd0, 1);
    step(0, 0, 0, 5'd0, 32'd0, 0);
    step(0, 0, 0, 5'd0, 32'd0, 0);
    // Misaligned LSB (masked and flagged only with alignment enabled).
    step(0, 1, 1, 5'd2, 32'h0000_1FFF, 0);
    step(0, 1, 1, 5'd3, 32'h0000_0000, 0);
    // MSB write to a pending entry on the release edge.
    step(0, 1, 1, 5'd9, 32'h0000_0005, 1);
    step(0, 1, 1, 5'd9, 32'h0000_0006, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) b = ~b;
      a = ($urandom_range(0, 7) == 0) ? {1'b1, 4'($urandom)} : {1'b0, 4'($urandom)};
      d = $urandom;
      if ($urandom_range(0, 1) == 0) d[11:0] = '0;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           a, d, b);
    end
    step(0, 0, 0, 5'd0, 32'd0, 0);
    step(0, 0, 0, 5'd0, 32'd0, 0);
    #1;
    chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
